// File: rtl/i2c_eeprom_ctrl_pkg.sv
// Shared types and defaults for the I2C EEPROM-style slave controller.
package i2c_eeprom_ctrl_pkg;

  localparam logic [3:0] DevIdHiDefault = 4'b1000;

  typedef enum logic [3:0] {
    StIdle,
    StDevAddr,
    StDevAck,
    StWordAddr,
    StWaAck,
    StWrData,
    StWrAck,
    StRdLoad,
    StRdData,
    StRdMack
  } state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the clk domain and flags SCL edges and START/STOP conditions.
module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // [0] metastability flop, [1] synchronised value, [2] history
  logic [2:0] scl_q, sda_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_o      = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_eeprom_ctrl.sv
// I2C slave front-end for a byte-wide storage array: device/word addressing, sequential
// writes and reads with an auto-incrementing pointer.
module i2c_eeprom_ctrl
  import i2c_eeprom_ctrl_pkg::*;
#(
  parameter logic [3:0]  DEV_ID_HI = DevIdHiDefault,
  parameter int unsigned MEM_AW    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  input  logic              a2,
  input  logic              a1,
  input  logic              a0,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_bus_sync (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [MEM_AW-1:0]   ptr_q, ptr_d;
  logic                rw_q, rw_d;
  logic                busy_q, busy_d;
  logic                sda_oe_q, sda_oe_d;
  logic [1:0]          ld_cnt_q, ld_cnt_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic [7:0]          rx_byte;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    busy_d      = busy_q;
    sda_oe_d    = sda_oe_q;
    ld_cnt_d    = ld_cnt_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rx_byte     = {shift_q[6:0], sda_s};

    if (stop_det) begin
      state_d   = StIdle;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
    end else if (start_det) begin
      state_d   = StDevAddr;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle: ;
        StDevAddr: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte[7:1] == {DEV_ID_HI, a2, a1, a0}) begin
                state_d = StDevAck;
                busy_d  = 1'b1;
                rw_d    = rx_byte[0];
              end else begin
                state_d = StIdle;
                busy_d  = 1'b0;
              end
            end
          end
        end
        StDevAck: begin
          if (scl_fall && !sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (scl_rise && sda_oe_q && rw_q) begin
            // Fetch during the ACK high phase so the MSB is ready at its falling edge.
            state_d    = StRdLoad;
            mem_re_d   = 1'b1;
            mem_addr_d = ptr_q;
            ld_cnt_d   = 2'd0;
          end else if (scl_fall && sda_oe_q) begin
            sda_oe_d  = 1'b0;
            state_d   = StWordAddr;
            bit_cnt_d = '0;
          end
        end
        StWordAddr: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ptr_d   = MEM_AW'(rx_byte);
              state_d = StWaAck;
            end
          end
        end
        StWaAck, StWrAck: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              state_d   = StWrData;
              bit_cnt_d = '0;
            end
          end
        end
        StWrData: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = ptr_q;
              mem_wdata_d = rx_byte;
              ptr_d       = ptr_q + 1'b1;
              state_d     = StWrAck;
            end
          end
        end
        StRdLoad: begin
          if (ld_cnt_q == 2'd0) begin
            ld_cnt_d = 2'd1;
          end else if (ld_cnt_q == 2'd1) begin
            shift_d  = mem_rdata;
            ptr_d    = ptr_q + 1'b1;
            ld_cnt_d = 2'd2;
          end else if (scl_fall) begin
            state_d   = StRdData;
            sda_oe_d  = ~shift_q[7];
            bit_cnt_d = '0;
          end
        end
        StRdData: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d  = StRdMack;
              sda_oe_d = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        StRdMack: begin
          if (scl_rise) begin
            if (!sda_s) begin
              state_d    = StRdLoad;
              mem_re_d   = 1'b1;
              mem_addr_d = ptr_q;
              ld_cnt_d   = 2'd0;
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      ld_cnt_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      sda_oe_q    <= sda_oe_d;
      ld_cnt_q    <= ld_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/i2c_eeprom_ctrl.md
I2C_EEPROM_CTRL -- requirements
Module: i2c_eeprom_ctrl

Interface
REQ-001 Parameter DEV_ID_HI, default 4'b1000, upper four bits of the 7-bit device address.
REQ-002 Parameter MEM_AW, default 8, word-address width.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 scl_i  in  1  I2C clock from bus, asynchronous to clk.
REQ-006 sda_i  in  1  I2C data from bus, asynchronous to clk.
REQ-007 sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 a2, a1, a0  in  1 each  strap pins, low three device-address bits.
REQ-009 mem_addr  out  MEM_AW  word address to storage array.
REQ-010 mem_wdata  out  8  write byte.
REQ-011 mem_we  out  1  one-clk write strobe.
REQ-012 mem_re  out  1  one-clk read strobe.
REQ-013 mem_rdata  in  8  read byte, valid exactly 1 clk after mem_re.
REQ-014 busy  out  1  high from addressed START until STOP or NACK-abort.

Function
REQ-015 scl_i and sda_i SHALL pass 2-flop synchronizers plus one history flop; edges are detected on synchronized values.
REQ-016 START = synchronized SDA falling while SCL high; STOP = SDA rising while SCL high; both are recognized in every state.
REQ-017 SDA SHALL be sampled on SCL rising edge; sda_oe SHALL change only on the clk after an SCL falling edge.
REQ-018 States: IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WA_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_MACK.
REQ-019 START (incl. repeated START) from any state -> DEV_ADDR, bit counter cleared; STOP from any state -> IDLE, sda_oe=0.
REQ-020 DEV_ADDR shifts 8 bits MSB first; after 8th bit, match = byte[7:1] == {DEV_ID_HI,a2,a1,a0}.
REQ-021 No match -> IDLE, never drives SDA, no memory access; match -> DEV_ACK, busy=1, rw = byte[0].
REQ-022 DEV_ACK drives sda_oe=1 for the 9th SCL period; next falling edge -> WORD_ADDR if rw=0, RD_LOAD if rw=1.
REQ-023 WORD_ADDR shifts 8 bits, loads internal pointer (low MEM_AW bits), ACKs in WA_ACK, then -> WR_DATA.
REQ-024 WR_DATA shifts 8 bits; on 8th SCL rise, mem_we pulses 1 clk with mem_addr=pointer, mem_wdata=byte; WR_ACK ACKs; pointer increments; -> WR_DATA.
REQ-025 RD_LOAD pulses mem_re 1 clk with mem_addr=pointer, captures mem_rdata next clk into shift register before the first data SCL falling edge; pointer increments.
REQ-026 RD_DATA drives sda_oe = ~shift[7] MSB first, shifting on each SCL falling edge, 8 bits.
REQ-027 RD_MACK releases SDA, samples master bit on 9th SCL rise: 0 (ACK) -> RD_LOAD; 1 (NACK) -> IDLE, busy=0.
REQ-028 Pointer wraps all-ones -> 0; no other bound.
REQ-029 STOP or START arriving mid-byte SHALL discard the partial byte; no mem_we issued for it.
REQ-030 mem_we and mem_re SHALL never be high in the same clk.

Reset
REQ-031 reset_n low: state=IDLE, sda_oe=0, busy=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, pointer=0, synchronizer flops=1 (bus idle).
REQ-032 Reset deassertion mid-transaction SHALL leave the block in IDLE waiting for a new START.

Structure
REQ-033 State encoding and DEV_ID_HI default SHALL live in the shared i2c package.
REQ-034 One sub-module, i2c_bus_sync: synchronizers, SCL rise/fall pulses, START/STOP pulses.

Verification
REQ-035 Pins a=3'b101; write 0xA0? no: address byte 0x8A (1000_101,W), word 0x10, data 0x55,0x66, STOP -> ACK on all 4 bytes; mem_we at 0x10=0x55, 0x11=0x66.
REQ-036 Address byte 0x92 (mismatch) -> sda_oe stays 0 throughout; busy=0; no strobes.
REQ-037 Pointer 0xFF, read 0x8B, master ACK then NACK -> mem_re at 0xFF then 0x00; returned bytes equal mem_rdata; IDLE after NACK.
REQ-038 Write 0x8A, word 0x20, then repeated START, 0x8B, read one byte with NACK -> mem_re at 0x20, no mem_we.
REQ-039 STOP after 4 bits of a write data byte -> no mem_we, IDLE, busy=0.
REQ-040 reset_n pulsed low during RD_DATA -> sda_oe=0 same cycle, all outputs at REQ-031 values.
